// File: rtl/ls_arbiter.sv
// Local-store data memory arbiter: DMA > LSU > IFU fixed priority with an IFU
// anti-starvation override, same-cycle issue to a single-ported memory, and a
// one-stage read-return pipeline that steers registered read data back to the
// requester that issued the read.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   {dma,lsu,ifu}_req/_addr         requests and byte addresses (held until granted)
//   {dma,lsu}_we/_wdata             write enable and write data (IFU is read-only)
//   {dma,lsu,ifu}_gnt               combinational grant, at most one per cycle
//   {dma,lsu,ifu}_rvalid            registered one-cycle read-return valid
//   rdata, rerr                     shared read-return data and out-of-range flag
//   mem_*                           combinational memory pins; mem_readData in
module ls_arbiter #(
    parameter int unsigned MEM_QWORDS   = 2001,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         dma_req,
    input  logic         lsu_req,
    input  logic         ifu_req,
    input  logic         dma_we,
    input  logic         lsu_we,
    input  logic [31:0]  dma_addr,
    input  logic [31:0]  lsu_addr,
    input  logic [31:0]  ifu_addr,
    input  logic [127:0] dma_wdata,
    input  logic [127:0] lsu_wdata,
    output logic         dma_gnt,
    output logic         lsu_gnt,
    output logic         ifu_gnt,
    output logic         dma_rvalid,
    output logic         lsu_rvalid,
    output logic         ifu_rvalid,
    output logic [127:0] rdata,
    output logic         rerr,
    output logic [31:0]  mem_address,
    output logic [127:0] mem_writeData,
    output logic         mem_memWrite,
    output logic         mem_memRead,
    input  logic [127:0] mem_readData
);

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 128;
    localparam int unsigned QW   = AW - 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DMA  = 2'd1,
        OWN_LSU  = 2'd2,
        OWN_IFU  = 2'd3
    } owner_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    owner_e           owner_q, owner_d;
    logic             err_q, err_d;
    logic             dma_rvalid_q, dma_rvalid_d;
    logic             lsu_rvalid_q, lsu_rvalid_d;
    logic             ifu_rvalid_q, ifu_rvalid_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             rerr_q, rerr_d;

    logic             starve;
    logic             any_gnt;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [AW-1:0]    qaddr;
    logic [DW-1:0]    sel_wdata;
    logic             in_range;
    owner_e           sel_owner;

    // Arbitration and same-cycle issue to the memory
    always_comb begin
        dma_gnt   = 1'b0;
        lsu_gnt   = 1'b0;
        ifu_gnt   = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_owner = OWN_NONE;

        starve = ifu_req && (cnt_q == CNT_W'(STARVE_LIMIT));

        if (starve) begin
            ifu_gnt   = 1'b1;
            sel_addr  = ifu_addr;
            sel_owner = OWN_IFU;
        end else if (dma_req) begin
            dma_gnt   = 1'b1;
            sel_we    = dma_we;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
            sel_owner = OWN_DMA;
        end else if (lsu_req) begin
            lsu_gnt   = 1'b1;
            sel_we    = lsu_we;
            sel_addr  = lsu_addr;
            sel_wdata = lsu_wdata;
            sel_owner = OWN_LSU;
        end else if (ifu_req) begin
            ifu_gnt   = 1'b1;
            sel_addr  = ifu_addr;
            sel_owner = OWN_IFU;
        end

        any_gnt  = dma_gnt | lsu_gnt | ifu_gnt;
        qaddr    = sel_addr & ~AW'(32'hF);
        in_range = (qaddr[AW-1:4] < QW'(MEM_QWORDS));

        // Out-of-range accesses are granted but never reach the memory array
        mem_address   = qaddr;
        mem_writeData = sel_wdata;
        mem_memWrite  = any_gnt & sel_we & in_range;
        mem_memRead   = any_gnt & ~sel_we & in_range;
    end

    // Starvation counter and read-return pipeline next state
    always_comb begin
        cnt_d        = cnt_q;
        owner_d      = OWN_NONE;
        err_d        = 1'b0;
        dma_rvalid_d = 1'b0;
        lsu_rvalid_d = 1'b0;
        ifu_rvalid_d = 1'b0;
        rerr_d       = 1'b0;
        rdata_d      = rdata_q;

        if (!ifu_req || ifu_gnt) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(STARVE_LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Only reads produce a return; writes leave the pipeline empty
        if (any_gnt && !sel_we) begin
            owner_d = sel_owner;
            err_d   = ~in_range;
        end

        if (owner_q != OWN_NONE) begin
            dma_rvalid_d = (owner_q == OWN_DMA);
            lsu_rvalid_d = (owner_q == OWN_LSU);
            ifu_rvalid_d = (owner_q == OWN_IFU);
            rerr_d       = err_q;
            rdata_d      = err_q ? '0 : mem_readData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            owner_q      <= OWN_NONE;
            err_q        <= 1'b0;
            dma_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            ifu_rvalid_q <= 1'b0;
            rdata_q      <= '0;
            rerr_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            err_q        <= err_d;
            dma_rvalid_q <= dma_rvalid_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            ifu_rvalid_q <= ifu_rvalid_d;
            rdata_q      <= rdata_d;
            rerr_q       <= rerr_d;
        end
    end

    assign dma_rvalid = dma_rvalid_q;
    assign lsu_rvalid = lsu_rvalid_q;
    assign ifu_rvalid = ifu_rvalid_q;
    assign rdata      = rdata_q;
    assign rerr       = rerr_q;

endmodule

// File: tb/tb_ls_arbiter.sv
// Directed bench for ls_arbiter with a behavioural single-ported memory.
module tb_ls_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         dma_req, lsu_req, ifu_req;
    logic         dma_we, lsu_we;
    logic [31:0]  dma_addr, lsu_addr, ifu_addr;
    logic [127:0] dma_wdata, lsu_wdata;
    logic         dma_gnt, lsu_gnt, ifu_gnt;
    logic         dma_rvalid, lsu_rvalid, ifu_rvalid;
    logic [127:0] rdata;
    logic         rerr;
    logic [31:0]  mem_address;
    logic [127:0] mem_writeData;
    logic         mem_memWrite, mem_memRead;
    logic [127:0] mem_readData = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_count = 0;

    logic [127:0] mem [0:2000];

    ls_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .dma_req(dma_req), .lsu_req(lsu_req), .ifu_req(ifu_req),
        .dma_we(dma_we), .lsu_we(lsu_we),
        .dma_addr(dma_addr), .lsu_addr(lsu_addr), .ifu_addr(ifu_addr),
        .dma_wdata(dma_wdata), .lsu_wdata(lsu_wdata),
        .dma_gnt(dma_gnt), .lsu_gnt(lsu_gnt), .ifu_gnt(ifu_gnt),
        .dma_rvalid(dma_rvalid), .lsu_rvalid(lsu_rvalid), .ifu_rvalid(ifu_rvalid),
        .rdata(rdata), .rerr(rerr),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
        .mem_readData(mem_readData)
    );

    always #5 clk = ~clk;

    // Memory model: write at the edge, registered read, 0 when not reading
    always @(posedge clk) begin
        if (mem_memWrite) begin
            if (mem_address[31:4] < 28'd2001) mem[mem_address[14:4]] <= mem_writeData;
            wr_count <= wr_count + 1;
        end
        if (mem_memRead && mem_address[31:4] < 28'd2001) mem_readData <= mem[mem_address[14:4]];
        else mem_readData <= '0;
    end

    typedef struct {
        logic dr; logic dw; logic [31:0] da; logic [127:0] dd;
        logic lr; logic lw; logic [31:0] la; logic [127:0] ld;
        logic ir; logic [31:0] ia;
        logic [2:0] gnt; logic [31:0] ma; logic mw; logic mr; logic [127:0] md;
        logic [2:0] rv; logic re; logic [127:0] rd;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mkv(
        input logic dr, input logic dw, input logic [31:0] da, input logic [127:0] dd,
        input logic lr, input logic lw, input logic [31:0] la, input logic [127:0] ld,
        input logic ir, input logic [31:0] ia,
        input logic [2:0] gnt, input logic [31:0] ma, input logic mw, input logic mr,
        input logic [127:0] md, input logic [2:0] rv, input logic re, input logic [127:0] rd);
        vec_t v;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.lr = lr; v.lw = lw; v.la = la; v.ld = ld;
        v.ir = ir; v.ia = ia;
        v.gnt = gnt; v.ma = ma; v.mw = mw; v.mr = mr; v.md = md;
        v.rv = rv; v.re = re; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        dma_req = 0; lsu_req = 0; ifu_req = 0; dma_we = 0; lsu_we = 0;
        dma_addr = '0; lsu_addr = '0; ifu_addr = '0; dma_wdata = '0; lsu_wdata = '0;
    endtask

    task automatic drive_contend(input logic with_lsu, input logic with_ifu);
        dma_req = 1; dma_we = 0; dma_addr = 32'h100;
        lsu_req = with_lsu; lsu_we = 0; lsu_addr = 32'h110;
        ifu_req = with_ifu; ifu_addr = 32'h120;
    endtask

    function automatic logic [2:0] gnts();
        return {dma_gnt, lsu_gnt, ifu_gnt};
    endfunction

    function automatic logic [2:0] rvs();
        return {dma_rvalid, lsu_rvalid, ifu_rvalid};
    endfunction

    initial begin
        for (int i = 0; i < 2001; i++) mem[i] = 128'h1000 + 128'(i);
        drive_idle();
        rst_n = 0;

        //            dr dw da        dd       lr lw la     ld       ir ia      gnt     ma        mw mr md       rv      re rd
        vecs[0]  = mkv(1, 0, 32'h20,   0,       1, 0, 32'h40, 0,      1, 32'h60, 3'b100, 32'h20,   0, 1, 0,       3'b000, 0, 0);
        vecs[1]  = mkv(0, 0, 32'h0,    0,       1, 0, 32'h40, 0,      1, 32'h60, 3'b010, 32'h40,   0, 1, 0,       3'b000, 0, 0);
        vecs[2]  = mkv(0, 0, 32'h0,    0,       0, 0, 32'h0,  0,      1, 32'h6B, 3'b001, 32'h60,   0, 1, 0,       3'b100, 0, 128'h1002);
        vecs[3]  = mkv(0, 0, 32'h0,    0,       0, 0, 32'h0,  0,      0, 32'h0,  3'b000, 32'h0,    0, 0, 0,       3'b010, 0, 128'h1004);
        vecs[4]  = mkv(0, 0, 32'h0,    0,       0, 0, 32'h0,  0,      0, 32'h0,  3'b000, 32'h0,    0, 0, 0,       3'b001, 0, 128'h1006);
        vecs[5]  = mkv(0, 0, 32'h0,    0,       0, 0, 32'h0,  0,      0, 32'h0,  3'b000, 32'h0,    0, 0, 0,       3'b000, 0, 128'h1006);
        vecs[6]  = mkv(0, 0, 32'h0,    0,       1, 1, 32'h10, 120,    0, 32'h0,  3'b010, 32'h10,   1, 0, 120,     3'b000, 0, 128'h1006);
        vecs[7]  = mkv(0, 0, 32'h0,    0,       1, 0, 32'h1C, 0,      0, 32'h0,  3'b010, 32'h10,   0, 1, 0,       3'b000, 0, 128'h1006);
        vecs[8]  = mkv(0, 0, 32'h0,    0,       0, 0, 32'h0,  0,      0, 32'h0,  3'b000, 32'h0,    0, 0, 0,       3'b000, 0, 128'h1006);
        vecs[9]  = mkv(0, 0, 32'h0,    0,       0, 0, 32'h0,  0,      0, 32'h0,  3'b000, 32'h0,    0, 0, 0,       3'b010, 0, 120);
        vecs[10] = mkv(1, 0, 32'h7D10, 0,       0, 0, 32'h0,  0,      0, 32'h0,  3'b100, 32'h7D10, 0, 0, 0,       3'b000, 0, 120);
        vecs[11] = mkv(0, 0, 32'h0,    0,       0, 0, 32'h0,  0,      0, 32'h0,  3'b000, 32'h0,    0, 0, 0,       3'b000, 0, 120);
        vecs[12] = mkv(0, 0, 32'h0,    0,       0, 0, 32'h0,  0,      0, 32'h0,  3'b000, 32'h0,    0, 0, 0,       3'b100, 1, 0);
        vecs[13] = mkv(1, 1, 32'h7D10, 'hDEAD,  0, 0, 32'h0,  0,      0, 32'h0,  3'b100, 32'h7D10, 0, 0, 'hDEAD,  3'b000, 0, 0);
        vecs[14] = mkv(0, 0, 32'h0,    0,       0, 0, 32'h0,  0,      0, 32'h0,  3'b000, 32'h0,    0, 0, 0,       3'b000, 0, 0);
        vecs[15] = mkv(0, 0, 32'h0,    0,       0, 0, 32'h0,  0,      0, 32'h0,  3'b000, 32'h0,    0, 0, 0,       3'b000, 0, 0);
        vecs[16] = mkv(1, 1, 32'h30,   55,      1, 0, 32'h34, 0,      0, 32'h0,  3'b100, 32'h30,   1, 0, 55,      3'b000, 0, 0);
        vecs[17] = mkv(0, 0, 32'h0,    0,       1, 0, 32'h34, 0,      0, 32'h0,  3'b010, 32'h30,   0, 1, 0,       3'b000, 0, 0);
        vecs[18] = mkv(0, 0, 32'h0,    0,       0, 0, 32'h0,  0,      0, 32'h0,  3'b000, 32'h0,    0, 0, 0,       3'b000, 0, 0);
        vecs[19] = mkv(0, 0, 32'h0,    0,       0, 0, 32'h0,  0,      0, 32'h0,  3'b000, 32'h0,    0, 0, 0,       3'b010, 0, 55);

        // Reset state
        #12;
        chk("reset rvalid", 128'(rvs()), 0);
        chk("reset rdata", rdata, 0);
        chk("reset rerr", 128'(rerr), 0);
        chk("reset gnt", 128'(gnts()), 0);
        chk("reset mem_ctl", 128'({mem_memWrite, mem_memRead}), 0);
        @(negedge clk);
        rst_n = 1;

        // Table: priority, hazard, out-of-range, simultaneous write/read
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            dma_req = vecs[i].dr; dma_we = vecs[i].dw; dma_addr = vecs[i].da; dma_wdata = vecs[i].dd;
            lsu_req = vecs[i].lr; lsu_we = vecs[i].lw; lsu_addr = vecs[i].la; lsu_wdata = vecs[i].ld;
            ifu_req = vecs[i].ir; ifu_addr = vecs[i].ia;
            #1;
            chk($sformatf("row%0d gnt", i), 128'(gnts()), 128'(vecs[i].gnt));
            chk($sformatf("row%0d mem_address", i), 128'(mem_address), 128'(vecs[i].ma));
            chk($sformatf("row%0d mem_memWrite", i), 128'(mem_memWrite), 128'(vecs[i].mw));
            chk($sformatf("row%0d mem_memRead", i), 128'(mem_memRead), 128'(vecs[i].mr));
            chk($sformatf("row%0d mem_writeData", i), mem_writeData, vecs[i].md);
            chk($sformatf("row%0d rvalid", i), 128'(rvs()), 128'(vecs[i].rv));
            chk($sformatf("row%0d rerr", i), 128'(rerr), 128'(vecs[i].re));
            chk($sformatf("row%0d rdata", i), rdata, vecs[i].rd);
        end
        chk("memory write count", 128'(wr_count), 2);

        // IFU loses five times, then drops its request, clearing the counter
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive_contend(1'b0, c < 5);
            #1;
            chk($sformatf("pre c%0d gnt", c), 128'(gnts()), 128'(3'b100));
        end

        // Idle: nothing issued, returns drain then stop
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive_idle();
            #1;
            chk($sformatf("idle%0d gnt", k), 128'(gnts()), 0);
            chk($sformatf("idle%0d mem", k),
                128'({mem_address, mem_memWrite, mem_memRead}) | mem_writeData, 0);
            if (k >= 2) chk($sformatf("idle%0d rvalid", k), 128'(rvs()), 0);
        end

        // Starvation: forced IFU win after 8 losses, counter restarts from 0
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            drive_contend(1'b1, 1'b1);
            #1;
            if (c == 8 || c == 17) chk($sformatf("starve c%0d gnt", c), 128'(gnts()), 128'(3'b001));
            else chk($sformatf("starve c%0d gnt", c), 128'(gnts()), 128'(3'b100));
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_idle();
        end

        // Asynchronous reset with a read in flight
        @(negedge clk);
        dma_req = 1; dma_we = 0; dma_addr = 32'h20;
        @(posedge clk);
        #2;
        drive_idle();
        rst_n = 0;
        #1;
        chk("async rst rvalid", 128'(rvs()), 0);
        chk("async rst rdata", rdata, 0);
        chk("async rst rerr", 128'(rerr), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post rst%0d rvalid", k), 128'(rvs()), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ls_arbiter.md
Name: ls_arbiter

Overview:
- Arbitrates the single-ported 128-bit quadword-addressable local-store data memory between three requesters:
  - DMA engine (DMA)
  - SPU odd-pipe load/store unit (LSU)
  - instruction fetch unit (IFU)
- Sits between the requesters and the memory; drives the memory's address/writeData/memWrite/memRead pins.
- Routes the registered read data back to the requester that issued the read, with a per-requester valid.

Parameters:
- MEM_QWORDS, 2001: number of 128-bit quadwords in the memory; quadword index = addr>>4.
- STARVE_LIMIT, 8: consecutive cycles a pending IFU request may lose arbitration before it is forced to win.
- CNT_W, 4: width of the IFU starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- dma_req, lsu_req, ifu_req  in  1 each  access request, held until granted
- dma_we, lsu_we  in  1 each  1 = write, 0 = read (IFU is read-only)
- dma_addr, lsu_addr, ifu_addr  in  32 each  byte address
- dma_wdata, lsu_wdata  in  128 each  write data
- dma_gnt, lsu_gnt, ifu_gnt  out  1 each  request accepted this cycle (combinational)
- dma_rvalid, lsu_rvalid, ifu_rvalid  out  1 each  rdata valid for that requester (registered)
- rdata  out  128  shared read-return bus
- rerr  out  1  qualifies the active rvalid: access was out of range
- mem_address  out  32  to memory address
- mem_writeData  out  128  to memory writeData
- mem_memWrite, mem_memRead  out  1 each  to memory controls
- mem_readData  in  128  from memory readData (1-cycle registered, 0 when memRead was low)

Behaviour:
- Reset (async, rst_n=0): all rvalid=0, rerr=0, rdata=0, starvation counter=0, pending-owner register = NONE. Combinational outputs are 0 while no request is present.
- Reset asserted mid-operation: any in-flight read return is dropped; no rvalid after reset release for a pre-reset grant.
- Arbitration, combinational each cycle; exactly one gnt or none:
  - Default priority is DMA > LSU > IFU.
  - If ifu_req=1 and the counter equals STARVE_LIMIT, IFU wins over both others.
- Starvation counter:
  - Increments when ifu_req=1 and ifu_gnt=0, saturating at STARVE_LIMIT.
  - Clears on ifu_gnt, or when ifu_req=0.
- Issue, in the same cycle as gnt:
  - mem_address = winner addr with bits [3:0] forced to 0.
  - mem_writeData = winner wdata; IFU drives 0.
  - mem_memWrite = we.
  - mem_memRead = ~we.
  - With no winner: all mem_* are 0.
- Range check: if addr>>4 >= MEM_QWORDS:
  - The request is still granted.
  - mem_memWrite and mem_memRead are forced 0, so the memory is untouched.
  - For a read, the return carries rerr=1 and rdata=0.
  - For a write, nothing is returned.
- Read return:
  - Pipeline register owner/err is captured at the granting edge.
  - At the next edge, the owner's rvalid goes high for exactly 1 cycle and rdata is captured from mem_readData.
  - Rvalid is therefore visible 2 rising edges after gnt, one cycle after the memory's registered output.
- Writes produce no rvalid.
  - Write-then-read of the same address in back-to-back cycles returns the new data: the memory writes at edge N and reads at edge N+1.
- Throughput: one access per cycle, fully pipelined. Reads from different requesters may return on consecutive cycles.
- Simultaneous requests:
  - The loser keeps req high with stable addr/we/wdata.
  - The arbiter holds no request state; a dropped req is simply ignored.
- rdata holds its last value when no rvalid is asserted; rerr is 0 whenever all rvalid are 0.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with a read in flight -> all rvalid=0, rdata=0 immediately; no rvalid after release.
- Priority: DMA read 0x20, LSU read 0x40, IFU read 0x60 all asserted at once.
  - Required: dma_gnt in cycle 0, lsu_gnt in cycle 1, ifu_gnt in cycle 2.
  - Required: dma/lsu/ifu_rvalid at cycles 2/3/4 with the preloaded data of each address.
- Starvation: DMA and LSU request continuously while ifu_req=1.
  - Required: ifu_gnt exactly at the 9th cycle (counter=8); counter returns to 0; DMA regains the grant next cycle.
- Write/read hazard: LSU writes 128'd120 to 0x10, then LSU reads 0x1C the next cycle.
  - Required: mem_address=0x10 for both; lsu_rvalid with rdata=128'd120.
- Out of range: DMA reads 0x7D10 (index 2001).
  - Required: dma_gnt=1, mem_memRead=0, then dma_rvalid=1 with rerr=1 and rdata=0.
  - Required: a write to the same address leaves the memory unchanged and produces no rvalid.
- Idle: no requests for 10 cycles -> all mem_* = 0, no gnt, no rvalid, counter = 0.
